// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, synchronous ROM port, 1-entry skid buffer, stall/redirect control.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cu_wpcir,
    input  logic               cu_branch,
    input  logic [31:0]        br_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        if_inst,
    output logic [31:0]        if_pc4,
    output logic [3:0]         IF_ins_type,
    output logic [3:0]         IF_ins_number,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    output logic [1:0]         state_dbg
);

    // Handshake: the word on if_inst is consumed at the next posedge unless
    // cu_wpcir=1; cu_branch squashes it in the same cycle when not stalled.
    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_HOLD     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_reg, pc_nx;
    logic [31:0] inst_pc, inst_pc_nx;
    logic [31:0] hold_buf, hold_nx;
    logic [3:0]  seq, seq_nx;
    logic        live, redirect, accept, stall;
    logic [31:0] offered;
    logic [31:0] br_aligned;
    logic [5:0]  opcode;

    assign live       = (state == S_RUN) || (state == S_HOLD);
    assign stall      = live && cu_wpcir;
    assign redirect   = live && !cu_wpcir && cu_branch;
    assign accept     = live && !cu_wpcir && !cu_branch;
    assign offered    = (state == S_HOLD) ? hold_buf : imem_data;
    assign br_aligned = br_target & ~32'h0000_0003;

    assign imem_addr     = pc_reg[IMEM_AW+1:2];
    assign if_inst       = (live && !redirect) ? offered : 32'h0;
    assign if_pc4        = (live && !redirect) ? (inst_pc + 32'd4) : 32'h0;
    assign IF_ins_number = seq;
    assign state_dbg     = state;
    assign opcode        = if_inst[31:26];

    always_comb begin
        IF_ins_type = 4'd15;
        if (if_inst == 32'h0)              IF_ins_type = 4'd0;
        else if (opcode == 6'b000000)      IF_ins_type = 4'd1;
        else if (opcode[5:3] == 3'b001)    IF_ins_type = 4'd2;
        else if (opcode == 6'b100011)      IF_ins_type = 4'd3;
        else if (opcode == 6'b101011)      IF_ins_type = 4'd4;
        else if (opcode[5:1] == 5'b00010)  IF_ins_type = 4'd5;
        else if (opcode[5:1] == 5'b00001)  IF_ins_type = 4'd6;
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc_reg;
        inst_pc_nx = inst_pc;
        hold_nx    = hold_buf;
        seq_nx     = seq;
        case (state)
            S_BOOT, S_REDIRECT: begin
                inst_pc_nx = pc_reg;
                pc_nx      = pc_reg + 32'd4;
                state_nx   = S_RUN;
            end
            default: begin
                if (cu_wpcir) begin
                    // First stalled cycle captures the ROM word before it is overwritten.
                    state_nx = S_HOLD;
                    if (state == S_RUN) hold_nx = imem_data;
                end else if (cu_branch) begin
                    pc_nx    = br_aligned;
                    state_nx = S_REDIRECT;
                end else begin
                    inst_pc_nx = pc_reg;
                    pc_nx      = pc_reg + 32'd4;
                    seq_nx     = seq + 4'd1;
                    state_nx   = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            pc_reg   <= RESET_PC;
            inst_pc  <= RESET_PC;
            hold_buf <= 32'h0;
            seq      <= 4'd0;
        end else begin
            state    <= state_nx;
            pc_reg   <= pc_nx;
            inst_pc  <= inst_pc_nx;
            hold_buf <= hold_nx;
            seq      <= seq_nx;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (accept && (perf_fetch_q != 32'hFFFF_FFFF)) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall && (perf_stall_q != 32'hFFFF_FFFF))  perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, stall, branch, stall-over-branch, tag wrap, reset mid-HOLD.
module tb_if_stage;
    logic        clk;
    logic        rst_n;
    logic        cu_wpcir;
    logic        cu_branch;
    logic [31:0] br_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;
    logic [1:0]  state_dbg;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    localparam logic [31:0] W_A   = 32'h0000_1020; // R
    localparam logic [31:0] W_B   = 32'h2001_0005; // I-ALU
    localparam logic [31:0] W_C   = 32'h8c22_0004; // LOAD
    localparam logic [31:0] W_D   = 32'hac23_0008; // STORE
    localparam logic [31:0] W_BR  = 32'h1000_0010; // BRANCH
    localparam logic [31:0] W_J   = 32'h0800_0003; // JUMP
    localparam logic [31:0] W_OTH = 32'hfc00_0000; // OTHER

    logic [31:0] rom [256];
    wire  [71:0] obs = {if_inst, if_pc4, IF_ins_type, IF_ins_number};

    if_stage #(.RESET_PC(32'h0), .IMEM_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cu_wpcir(cu_wpcir), .cu_branch(cu_branch),
        .br_target(br_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_inst(if_inst), .if_pc4(if_pc4), .IF_ins_type(IF_ins_type),
        .IF_ins_number(IF_ins_number),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous ROM, one cycle of read latency
    always @(posedge clk) imem_data <= rom[imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cu_wpcir = 1'b0; cu_branch = 1'b0; br_target = 32'h0;
        cyc(); cyc();
        nvec++; if ({obs, state_dbg, imem_addr} !== {72'h0, 2'd0, 8'h00}) begin
            nerr++; $display("FAIL in_reset got %h want 0", {obs, state_dbg, imem_addr}); end
        rst_n = 1'b1;
        #1;
        nvec++; if ({obs, state_dbg} !== {72'h0, 2'd0}) begin
            nerr++; $display("FAIL boot_bubble got %h want 0", {obs, state_dbg}); end
        cyc();
        nvec++; if (obs !== {W_A, 32'd4, 4'd1, 4'd0}) begin
            nerr++; $display("FAIL first_a got %h want %h", obs, {W_A, 32'd4, 4'd1, 4'd0}); end
        cyc();
        nvec++; if (obs !== {W_B, 32'd8, 4'd2, 4'd1}) begin
            nerr++; $display("FAIL second_b got %h want %h", obs, {W_B, 32'd8, 4'd2, 4'd1}); end
    endtask

    task automatic test_stall();
        cu_wpcir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) cu_wpcir = 1'b0;
            #1;
            nvec++; if (obs !== {W_B, 32'd8, 4'd2, 4'd1}) begin
                nerr++; $display("FAIL stall_hold_%0d got %h want %h", k, obs, {W_B, 32'd8, 4'd2, 4'd1}); end
            if (k > 0) begin
                nvec++; if (state_dbg !== 2'd2) begin
                    nerr++; $display("FAIL stall_state_%0d got %0d want 2", k, state_dbg); end
            end
            cyc();
        end
        nvec++; if (obs !== {W_C, 32'd12, 4'd3, 4'd2}) begin
            nerr++; $display("FAIL after_stall_c got %h want %h", obs, {W_C, 32'd12, 4'd3, 4'd2}); end
`ifdef IF_PERF_CNT_EN
        nvec++; if ({perf_stall_cnt, perf_fetch_cnt} !== {32'd3, 32'd2}) begin
            nerr++; $display("FAIL perf_counts got %h want %h", {perf_stall_cnt, perf_fetch_cnt}, {32'd3, 32'd2}); end
`endif
    endtask

    task automatic test_branch();
        cu_branch = 1'b1; br_target = 32'h0000_0043;
        #1;
        nvec++; if (obs !== {64'h0, 4'd0, 4'd2}) begin
            nerr++; $display("FAIL branch_squash got %h want %h", obs, {64'h0, 4'd0, 4'd2}); end
        cyc();
        cu_branch = 1'b0; br_target = 32'h0;
        #1;
        nvec++; if ({obs, state_dbg} !== {64'h0, 4'd0, 4'd2, 2'd3}) begin
            nerr++; $display("FAIL redirect_bubble got %h want %h", {obs, state_dbg}, {64'h0, 4'd0, 4'd2, 2'd3}); end
        cyc();
        nvec++; if (obs !== {W_BR, 32'h44, 4'd5, 4'd2}) begin
            nerr++; $display("FAIL target_word got %h want %h", obs, {W_BR, 32'h44, 4'd5, 4'd2}); end
        cyc();
        nvec++; if (obs !== {W_J, 32'h48, 4'd6, 4'd3}) begin
            nerr++; $display("FAIL target_next got %h want %h", obs, {W_J, 32'h48, 4'd6, 4'd3}); end
    endtask

    task automatic test_stall_beats_branch();
        cu_wpcir = 1'b1; cu_branch = 1'b1; br_target = 32'h80;
        #1;
        nvec++; if (obs !== {W_J, 32'h48, 4'd6, 4'd3}) begin
            nerr++; $display("FAIL stall_br_same got %h want %h", obs, {W_J, 32'h48, 4'd6, 4'd3}); end
        cyc();
        nvec++; if ({obs, state_dbg} !== {W_J, 32'h48, 4'd6, 4'd3, 2'd2}) begin
            nerr++; $display("FAIL stall_br_hold got %h want %h", {obs, state_dbg}, {W_J, 32'h48, 4'd6, 4'd3, 2'd2}); end
        cu_wpcir = 1'b0; cu_branch = 1'b0; br_target = 32'h0;
        cyc();
        nvec++; if (obs !== {W_OTH, 32'h4c, 4'd15, 4'd4}) begin
            nerr++; $display("FAIL stall_br_seq got %h want %h", obs, {W_OTH, 32'h4c, 4'd15, 4'd4}); end
    endtask

    task automatic test_wrap_and_reset();
        logic [3:0] et;
        rst_n = 1'b0; #3;
        cyc();
        rst_n = 1'b1;
        #1;
        nvec++; if (obs !== 72'h0) begin
            nerr++; $display("FAIL wrap_boot got %h want 0", obs); end
        cyc();
        for (int i = 0; i < 17; i++) begin
            case (i)
                0: et = 4'd1; 1: et = 4'd2; 2: et = 4'd3; 3: et = 4'd4; 16: et = 4'd5;
                default: et = 4'd2;
            endcase
            nvec++; if (obs !== {rom[i], 32'(4 * (i + 1)), et, 4'(i % 16)}) begin
                nerr++; $display("FAIL wrap_%0d got %h want %h", i, obs, {rom[i], 32'(4 * (i + 1)), et, 4'(i % 16)}); end
            cyc();
        end
        cu_wpcir = 1'b1;
        cyc();
        nvec++; if ({obs, state_dbg} !== {W_J, 32'h48, 4'd6, 4'd1, 2'd2}) begin
            nerr++; $display("FAIL pre_rst_hold got %h want %h", {obs, state_dbg}, {W_J, 32'h48, 4'd6, 4'd1, 2'd2}); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({obs, state_dbg} !== {72'h0, 2'd0}) begin
            nerr++; $display("FAIL mid_hold_rst got %h want 0", {obs, state_dbg}); end
        rst_n = 1'b1; cu_wpcir = 1'b0;
        cyc();
        nvec++; if (obs !== {W_A, 32'd4, 4'd1, 4'd0}) begin
            nerr++; $display("FAIL restart_a got %h want %h", obs, {W_A, 32'd4, 4'd1, 4'd0}); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf_sat();
        force dut.perf_fetch_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_fetch_q;
        cyc(); cyc();
        nvec++; if (perf_fetch_cnt !== 32'hFFFF_FFFF) begin
            nerr++; $display("FAIL perf_sat got %h want ffffffff", perf_fetch_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 + 32'(i);
        rom[0] = W_A; rom[1] = W_B; rom[2] = W_C; rom[3] = W_D;
        rom[16] = W_BR; rom[17] = W_J; rom[18] = W_OTH;
        imem_data = 32'h0;
        test_reset();
        test_stall();
        test_branch();
        test_stall_beats_branch();
        test_wrap_and_reset();
`ifdef IF_PERF_CNT_EN
        test_perf_sat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
